// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer: one holding slot per output port, valid/ready
// on every side, and a wrapping 16-bit delivery counter per port.

module demux_1x2_slot #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rdy_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [15:0]      cnt_o,
  output logic             free_o
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             drain;

  assign drain  = (state_q == FULL) & rdy_i;
  // A full slot can take a new word in the same cycle it is drained.
  assign free_o = (state_q == EMPTY) | rdy_i;
  assign vld_o  = (state_q == FULL);
  assign data_o = data_q;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (drain) cnt_d = cnt_q + 16'd1;
    case (state_q)
      EMPTY: begin
        if (acc_i) begin
          state_d = FULL;
          data_d  = data_i;
        end
      end
      FULL: begin
        if (acc_i)      data_d  = data_i;
        else if (drain) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end
endmodule

module demux_1x2_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_ctrl,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2
);
  logic [1:0]            acc, rdy, vld, free;
  logic [1:0][WIDTH-1:0] data;
  logic [1:0][15:0]      cnt;
  logic                  take;

  assign in_ready = in_ctrl ? free[1] : free[0];
  assign take     = in_valid & in_ready;
  assign acc      = {take & in_ctrl, take & ~in_ctrl};
  assign rdy      = {out2_ready, out1_ready};

  for (genvar k = 0; k < 2; k++) begin : g_slot
    demux_1x2_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .acc_i  (acc[k]),
      .data_i (in_data),
      .rdy_i  (rdy[k]),
      .vld_o  (vld[k]),
      .data_o (data[k]),
      .cnt_o  (cnt[k]),
      .free_o (free[k])
    );
  end

  assign out1_valid = vld[0];
  assign out2_valid = vld[1];
  assign out1_data  = data[0];
  assign out2_data  = data[1];
  assign cnt1       = cnt[0];
  assign cnt2       = cnt[1];
endmodule

// File: doc/demux_1x2_reg.md
DEMUX_1X2_REG -- requirements
Module: demux_1x2_reg

Interface
REQ-001 Parameter: WIDTH, 64, data width of the input word and both output words.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_ctrl  input  1  destination select: 0 selects port 1, 1 selects port 2.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 out1_valid  output  1  port 1 holds a word.
REQ-009 out1_ready  input  1  port 1 consumer takes the word.
REQ-010 out1_data  output  WIDTH  port 1 word.
REQ-011 out2_valid  output  1  port 2 holds a word.
REQ-012 out2_ready  input  1  port 2 consumer takes the word.
REQ-013 out2_data  output  WIDTH  port 2 word.
REQ-014 cnt1  output  16  number of words delivered on port 1; wraps modulo 2^16.
REQ-015 cnt2  output  16  number of words delivered on port 2; wraps modulo 2^16.

Function
REQ-016 Each port SHALL own one holding register, slot_k, with a valid flag v_k; outk_valid SHALL equal v_k, and outk_data SHALL equal the slot_k contents, driven directly from the register.
REQ-017 Input transfer (accept) SHALL occur when in_valid and in_ready are both 1 on a rising edge; output transfer (drain) on port k SHALL occur when outk_valid and outk_ready are both 1.
REQ-018 in_ready SHALL be (!v1 | out1_ready) when in_ctrl=0, and (!v2 | out2_ready) when in_ctrl=1; in_ready SHALL NOT depend on in_valid.
REQ-019 An accepted word SHALL appear on the selected port on the cycle after acceptance, giving a latency of 1 cycle; the other port's slot and flag SHALL be unchanged.
REQ-020 Each slot SHALL follow a two-state machine, EMPTY (v=0) and FULL (v=1):
- EMPTY -> FULL on accept to that port.
- FULL -> EMPTY on drain without accept.
- FULL -> FULL with new data on drain plus accept in the same cycle.
- FULL -> FULL holding data when neither occurs.
REQ-021 Simultaneous drain and accept on the same port SHALL sustain one word per cycle with no bubble and no loss.
REQ-022 A word held in a FULL slot SHALL remain stable (data and valid) until drained, regardless of in_ctrl, in_valid or the other port.
REQ-023 Each port SHALL drain independently; backpressure on one port SHALL NOT block accepts destined for the other port.
REQ-024 cnt_k SHALL increment by 1 on each drain on port k; it SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-025 Words to the same port SHALL be delivered in acceptance order; no ordering is guaranteed between ports.
REQ-026 in_data and in_ctrl SHALL be ignored when in_valid=0; the outk_ready inputs SHALL be ignored when outk_valid=0.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL clear v1 and v2 and reset cnt1 and cnt2 to 0; slot data SHALL be 0.
REQ-028 Reset SHALL take priority over any simultaneous accept or drain; words in flight SHALL be discarded.
REQ-029 During reset, out1_valid and out2_valid SHALL read 0; in_ready SHALL follow REQ-018 using the cleared flags, and therefore reads 1.

Verification
REQ-030 Reset, then a single word: in_ctrl=0, in_data=0xA5A5_0000_0000_0001, out1_ready=0 -> out1_valid=1 next cycle with that data, out2_valid=0, cnt1=0.
REQ-031 Port-1 backpressure: slot 1 FULL, out1_ready=0, and a second word offered with in_ctrl=0 -> in_ready=0 and the word is held upstream; then offered with in_ctrl=1, data 0x2 -> accepted, and out2_data=0x2 next cycle.
REQ-032 Streaming: 8 words to port 2 on back-to-back cycles with out2_ready held at 1 -> 8 contiguous out2_valid cycles in order, in_ready constantly 1, cnt2=8.
REQ-033 Wrap: 65537 drains on port 1 -> cnt1=1, and cnt2 unchanged.
REQ-034 Reset mid-operation: both slots FULL, rst_n=0 for one cycle while in_valid=1 -> next cycle v1=v2=0, cnt1=cnt2=0, and nothing is delivered.
REQ-035 Alternating destinations: in_ctrl toggled every cycle, both readies at 1, data 1..10 -> odd values on port 1 and even values on port 2, in order, with cnt1=cnt2=5.
